// File: rtl/prince_ctrl_pkg.sv
// Shared types and constants for the PRINCE round sequencer and its layer counter.
package prince_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FWD,
        MID_S,
        MID_SI,
        INV,
        FINAL
    } phase_t;

    localparam logic [1:0] LIN_NONE = 2'd0;
    localparam logic [1:0] LIN_M    = 2'd1;
    localparam logic [1:0] LIN_MP   = 2'd2;
    localparam logic [1:0] LIN_MINV = 2'd3;

    localparam logic [3:0] N_FWD    = 4'd5;
    localparam logic [3:0] N_INV    = 4'd5;
    localparam logic [3:0] RC_FINAL = 4'd11;

    function automatic logic is_sbox_phase(input phase_t p);
        return (p == FWD) || (p == MID_S) || (p == MID_SI) || (p == INV);
    endfunction

endpackage

// File: rtl/prince_round_ctrl_if.sv
// Control bundle between the round sequencer (master) and the PRINCE datapath (slave).
// Handshake: start is a request sampled only while idle; rand_req/rand_valid pair per S-box cycle.
interface prince_round_ctrl_if;
    import prince_ctrl_pkg::*;

    logic       start;
    logic       rand_valid;
    logic       busy;
    logic       done;
    logic       load_en;
    logic       sbox_en;
    logic       sbox_inv;
    logic       pre_add;
    logic       post_add;
    logic [1:0] lin_sel;
    logic       state_en;
    logic       final_en;
    logic [3:0] rc_idx;
    logic       rand_req;
    phase_t     phase;

    modport master (
        input  start, rand_valid,
        output busy, done, load_en, sbox_en, sbox_inv, pre_add, post_add,
               lin_sel, state_en, final_en, rc_idx, rand_req, phase
    );

    modport slave (
        output start, rand_valid,
        input  busy, done, load_en, sbox_en, sbox_inv, pre_add, post_add,
               lin_sel, state_en, final_en, rc_idx, rand_req, phase
    );

endinterface

// File: rtl/prince_round_ctrl_layer_cnt.sv
// Cycle-within-layer counter for the pipelined TI S-box layer; wraps at SBOX_LAT-1.
module prince_layer_cnt #(
    parameter int SBOX_LAT = 2,
    localparam int W = (SBOX_LAT > 1) ? $clog2(SBOX_LAT) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] lc,
    output logic         first,
    output logic         last
);

    assign first = (lc == '0);
    assign last  = (lc == W'(SBOX_LAT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            lc <= '0;
        end else if (en) begin
            lc <= last ? '0 : lc + 1'b1;
        end
    end

endmodule

// File: rtl/prince_round_ctrl.sv
// PRINCE round sequencer: whitening, 5 forward rounds, middle layer, 5 inverse rounds, final whitening.
// Optional PRINCE_CTRL_RAND_STALL_EN: S-box cycles wait for rand_valid.
module prince_round_ctrl
    import prince_ctrl_pkg::*;
#(
    parameter int SBOX_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    prince_round_ctrl_if.master  ctl
);

    phase_t     phase_q, phase_d;
    logic [3:0] rnd_q, rnd_d;
    logic       done_q, done_d;
    logic       in_sbox, stall, adv, lc_first, lc_last;
    logic [(SBOX_LAT > 1 ? $clog2(SBOX_LAT) : 1)-1:0] lc;

    assign in_sbox = is_sbox_phase(phase_q);

`ifdef PRINCE_CTRL_RAND_STALL_EN
    assign stall = in_sbox & ~ctl.rand_valid;
`else
    assign stall = 1'b0;
`endif

    assign adv = in_sbox & ~stall;

    prince_layer_cnt #(.SBOX_LAT(SBOX_LAT)) u_layer_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (adv),
        .lc    (lc),
        .first (lc_first),
        .last  (lc_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= IDLE;
            rnd_q   <= 4'd1;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        rnd_d   = rnd_q;
        done_d  = 1'b0;
        case (phase_q)
            IDLE:   if (ctl.start) phase_d = LOAD;
            LOAD: begin
                phase_d = FWD;
                rnd_d   = 4'd1;
            end
            FWD: if (adv && lc_last) begin
                if (rnd_q == N_FWD) phase_d = MID_S;
                else                rnd_d   = rnd_q + 4'd1;
            end
            MID_S:  if (adv && lc_last) phase_d = MID_SI;
            MID_SI: if (adv && lc_last) begin
                phase_d = INV;
                rnd_d   = N_FWD + 4'd1;
            end
            INV: if (adv && lc_last) begin
                if (rnd_q == N_FWD + N_INV) phase_d = FINAL;
                else                        rnd_d   = rnd_q + 4'd1;
            end
            FINAL: begin
                phase_d = IDLE;
                rnd_d   = 4'd1;
                done_d  = 1'b1;
            end
            default: phase_d = IDLE;
        endcase
    end

    // Layer-wide controls (lin_sel, sbox_inv) depend only on phase, so they never change mid-layer.
    always_comb begin
        ctl.busy     = (phase_q != IDLE);
        ctl.done     = done_q;
        ctl.phase    = phase_q;
        ctl.load_en  = 1'b0;
        ctl.sbox_en  = adv;
        ctl.sbox_inv = 1'b0;
        ctl.pre_add  = 1'b0;
        ctl.post_add = 1'b0;
        ctl.lin_sel  = LIN_NONE;
        ctl.state_en = adv & lc_last;
        ctl.final_en = 1'b0;
        ctl.rc_idx   = 4'd0;
        ctl.rand_req = in_sbox;
        case (phase_q)
            LOAD: ctl.load_en = 1'b1;
            FWD: begin
                ctl.lin_sel  = LIN_M;
                ctl.rc_idx   = rnd_q;
                ctl.post_add = adv & lc_last;
            end
            MID_S:  ctl.lin_sel = LIN_MP;
            MID_SI: ctl.sbox_inv = 1'b1;
            INV: begin
                ctl.sbox_inv = 1'b1;
                ctl.lin_sel  = LIN_MINV;
                ctl.rc_idx   = rnd_q;
                ctl.pre_add  = adv & lc_first;
            end
            FINAL: begin
                ctl.final_en = 1'b1;
                ctl.state_en = 1'b1;
                ctl.rc_idx   = RC_FINAL;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_prince_round_ctrl.sv
// Bench for prince_round_ctrl: three instances (SBOX_LAT 1, 2, 4) against a slot-schedule reference model.
module tb_prince_round_ctrl;
    import prince_ctrl_pkg::*;

`ifdef PRINCE_CTRL_RAND_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif
    localparam int LAT [3] = '{1, 2, 4};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic rand_valid = 1'b1;
    bit   mon_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    prince_round_ctrl_if if1 ();
    prince_round_ctrl_if if2 ();
    prince_round_ctrl_if if4 ();
    assign if1.start = start;  assign if1.rand_valid = rand_valid;
    assign if2.start = start;  assign if2.rand_valid = rand_valid;
    assign if4.start = start;  assign if4.rand_valid = rand_valid;

    prince_round_ctrl #(.SBOX_LAT(1)) dut1 (.clk(clk), .rst(rst), .ctl(if1));
    prince_round_ctrl #(.SBOX_LAT(2)) dut2 (.clk(clk), .rst(rst), .ctl(if2));
    prince_round_ctrl #(.SBOX_LAT(4)) dut4 (.clk(clk), .rst(rst), .ctl(if4));

    logic [16:0] act [3];
    assign act[0] = {if1.busy, if1.done, if1.load_en, if1.sbox_en, if1.sbox_inv, if1.pre_add, if1.post_add,
                     if1.lin_sel, if1.state_en, if1.final_en, if1.rc_idx, if1.rand_req};
    assign act[1] = {if2.busy, if2.done, if2.load_en, if2.sbox_en, if2.sbox_inv, if2.pre_add, if2.post_add,
                     if2.lin_sel, if2.state_en, if2.final_en, if2.rc_idx, if2.rand_req};
    assign act[2] = {if4.busy, if4.done, if4.load_en, if4.sbox_en, if4.sbox_inv, if4.pre_add, if4.post_add,
                     if4.lin_sel, if4.state_en, if4.final_en, if4.rc_idx, if4.rand_req};

    // Reference: a run is a flat list of slots: LOAD, 12 layers of L cycles, FINAL.
    function automatic logic [16:0] model_out(int l, bit active, int slot, bit rv, bit dn);
        logic busy = 0, ld = 0, sb = 0, inv = 0, pre = 0, post = 0, st = 0, fin = 0, rr = 0;
        logic [1:0] lin = 0;
        logic [3:0] rc = 0;
        int s, layer, sub;
        bit gate;
        if (active) begin
            busy = 1;
            if (slot == 0) ld = 1;
            else if (slot == 12 * l + 1) begin
                fin = 1; st = 1; rc = 4'd11;
            end else begin
                s = slot - 1; layer = s / l; sub = s % l;
                gate = STALL ? rv : 1'b1;
                sb = gate; rr = 1;
                st = (sub == l - 1) && gate;
                inv = (layer >= 6);
                if (layer < 5) begin
                    lin = 2'd1; rc = 4'(layer + 1); post = st;
                end else if (layer == 5) lin = 2'd2;
                else if (layer == 6) lin = 2'd0;
                else begin
                    lin = 2'd3; rc = 4'(layer - 1); pre = (sub == 0) && gate;
                end
            end
        end
        return {busy, dn, ld, sb, inv, pre, post, lin, st, fin, rc, rr};
    endfunction

    bit m_active [3] = '{0, 0, 0};
    int m_slot   [3] = '{0, 0, 0};
    bit m_done   [3] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_active[i] = 0; m_done[i] = 0;
            end else begin
                m_done[i] = 0;
                if (!m_active[i]) begin
                    if (start) begin m_active[i] = 1; m_slot[i] = 0; end
                end else if (m_slot[i] == 12 * LAT[i] + 1) begin
                    m_active[i] = 0; m_done[i] = 1;
                end else if (!(STALL && !rand_valid && m_slot[i] != 0)) begin
                    m_slot[i]++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++)
                check($sformatf("model_lat%0d", LAT[i]), 32'(act[i]),
                      32'(model_out(LAT[i], m_active[i], m_slot[i], rand_valid, m_done[i])));
        end
    end

    typedef struct {
        int         cyc;
        bit         start_in;
        logic       busy, done, load, fin, st;
        logic [3:0] rc;
        logic [1:0] lin;
    } vec_t;
    vec_t tbl [19];

    task automatic wait_idle();
        int n = 0;
        while ((if1.busy || if2.busy || if4.busy) && n < 100) begin
            @(negedge clk); n++;
        end
        check("wait_idle_timeout", 32'(n < 100), 32'd1);
    endtask

    // Starts all three instances together and times the done pulse of each.
    task automatic timed_run(input int stall_from, input int stall_len);
        int got [3] = '{0, 0, 0};
        wait_idle();
        @(posedge clk); #1; start = 1;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk); #1;
            start = 0;
            rand_valid = !(n >= stall_from && n < stall_from + stall_len);
            @(negedge clk);
            if (if1.done && got[0] == 0) got[0] = n;
            if (if2.done && got[1] == 0) got[1] = n;
            if (if4.done && got[2] == 0) got[2] = n;
        end
        rand_valid = 1;
        for (int i = 0; i < 3; i++)
            check($sformatf("done_cycle_lat%0d", LAT[i]), 32'(got[i]),
                  32'(12 * LAT[i] + 3 + (STALL ? stall_len : 0)));
    endtask

    initial begin
        int ix, ndone;
        tbl = '{
            '{1,  0, 1, 0, 1, 0, 0, 4'd0,  2'd0},
            '{2,  0, 1, 0, 0, 0, 0, 4'd1,  2'd1},
            '{3,  0, 1, 0, 0, 0, 1, 4'd1,  2'd1},
            '{4,  1, 1, 0, 0, 0, 0, 4'd2,  2'd1},
            '{5,  0, 1, 0, 0, 0, 1, 4'd2,  2'd1},
            '{11, 0, 1, 0, 0, 0, 1, 4'd5,  2'd1},
            '{12, 0, 1, 0, 0, 0, 0, 4'd0,  2'd2},
            '{13, 0, 1, 0, 0, 0, 1, 4'd0,  2'd2},
            '{14, 0, 1, 0, 0, 0, 0, 4'd0,  2'd0},
            '{15, 0, 1, 0, 0, 0, 1, 4'd0,  2'd0},
            '{16, 0, 1, 0, 0, 0, 0, 4'd6,  2'd3},
            '{17, 0, 1, 0, 0, 0, 1, 4'd6,  2'd3},
            '{25, 0, 1, 0, 0, 0, 1, 4'd10, 2'd3},
            '{26, 0, 1, 0, 0, 1, 1, 4'd11, 2'd0},
            '{27, 1, 0, 1, 0, 0, 0, 4'd0,  2'd0},
            '{28, 0, 1, 0, 1, 0, 0, 4'd0,  2'd0},
            '{53, 0, 1, 0, 0, 1, 1, 4'd11, 2'd0},
            '{54, 0, 0, 1, 0, 0, 0, 4'd0,  2'd0},
            '{55, 0, 0, 0, 0, 0, 0, 4'd0,  2'd0}
        };

        repeat (3) @(posedge clk);
        #1; mon_en = 1;
        @(negedge clk);
        check("reset_busy", 32'(if2.busy), 32'd0);
        check("reset_phase", 32'(if2.phase), 32'(IDLE));
        rst = 0;

        // Table run (SBOX_LAT=2): ignored start while busy, accepted start in the done cycle.
        @(posedge clk); #1; start = 1;
        ix = 0;
        for (int c = 1; c <= 55; c++) begin
            @(posedge clk); #1;
            start = 0;
            for (int k = 0; k < 19; k++) if (tbl[k].cyc == c) start = tbl[k].start_in;
            @(negedge clk);
            if (ix < 19 && tbl[ix].cyc == c) begin
                check($sformatf("tbl_c%0d", c),
                      32'({if2.busy, if2.done, if2.load_en, if2.final_en, if2.state_en, if2.rc_idx, if2.lin_sel}),
                      32'({tbl[ix].busy, tbl[ix].done, tbl[ix].load, tbl[ix].fin, tbl[ix].st, tbl[ix].rc, tbl[ix].lin}));
                ix++;
            end
        end
        start = 0;

        timed_run(0, 0);

        // Reset in cycle 10, then silence, then a fresh run.
        wait_idle();
        @(posedge clk); #1; start = 1;
        for (int n = 1; n <= 11; n++) begin
            @(posedge clk); #1;
            start = 0;
            rst = (n == 10);
            @(negedge clk);
        end
        rst = 0;
        check("rst_busy", 32'(if2.busy), 32'd0);
        check("rst_phase", 32'(if2.phase), 32'(IDLE));
        check("rst_outputs", 32'(act[1]), 32'd0);
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (if1.done || if2.done || if4.done) ndone++;
        end
        check("rst_no_done", 32'(ndone), 32'd0);
        timed_run(0, 0);

        // Randomness stall inside FWD round 3 of the SBOX_LAT=2 run.
        timed_run(6, 3);

        // Random traffic; the reference model checks every cycle.
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk); #1;
            start      = ($urandom_range(0, 7) == 0);
            rand_valid = ($urandom_range(0, 3) != 0);
            rst        = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1;
        start = 0; rand_valid = 1; rst = 0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prince_round_ctrl.md
# prince_round_ctrl

Round sequencer for the round-based, threshold-implemented PRINCE core. It steps the shared state register through whitening, 5 forward rounds, the middle layer (S, M', S⁻¹), 5 inverse rounds and final whitening. It drives the S-box pipeline enables, the linear-layer select (M, M', M⁻¹), round-constant index and key-add controls. It owns no data, only control, and sits beside the datapath that instantiates the TI S-box and linear layers.

## Interface
Parameters:
- SBOX_LAT, 2, register stages in the TI S-box layer (legal 1..4); one S-box layer occupies SBOX_LAT cycles

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin encryption; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; state register holds the ciphertext shares
- load_en  out  1  state <= pt ^ k0 ^ k1 ^ RC0
- sbox_en  out  1  advance the TI S-box pipeline
- sbox_inv  out  1  0 = S, 1 = S⁻¹
- pre_add  out  1  XOR RC[rc_idx] ^ k1 at the S-box input (inverse rounds)
- post_add  out  1  XOR RC[rc_idx] ^ k1 after the linear layer (forward rounds)
- lin_sel  out  2  0 none, 1 M, 2 M', 3 M⁻¹
- state_en  out  1  capture datapath result into state register
- final_en  out  1  state <= state ^ RC11 ^ k1 ^ k0'
- rc_idx  out  4  round-constant index 0..11
- rand_req  out  1  fresh randomness consumed this cycle
- rand_valid  in  1  fresh randomness available

## Operation
- Phases: IDLE, LOAD, FWD, MID_S, MID_SI, INV, FINAL. There is a round counter rnd (1..10) and a layer counter lc (0..SBOX_LAT-1).
- IDLE: all outputs 0. start=1 moves to LOAD.
- LOAD (1 cycle): load_en=1, rc_idx=0. Next phase is FWD with rnd=1 and lc=0.
- FWD: sbox_en=1, sbox_inv=0, lin_sel=1, rc_idx=rnd. On lc=SBOX_LAT-1: post_add=1, state_en=1. After rnd=5, move to MID_S, else rnd+1.
- MID_S: sbox_inv=0, lin_sel=2. state_en on the last lc, then move to MID_SI.
- MID_SI: sbox_inv=1, lin_sel=0. state_en on the last lc. Next phase is INV with rnd=6.
- INV: sbox_inv=1, lin_sel=3, pre_add=1 on lc=0 (input-side logic feeds pipeline stage 0), rc_idx=rnd. state_en on the last lc. After rnd=10, move to FINAL.
- FINAL (1 cycle): final_en=1, rc_idx=11, state_en=1. Next is IDLE with done=1 in that first IDLE cycle.
- lin_sel and sbox_inv are held constant for the whole layer, never changing mid-layer.
- start while busy is ignored; a start coinciding with the done cycle is accepted (done and busy both meaningful).
- rand_req = sbox_en in all S-box cycles.
- Reset (any phase, including mid-layer): IDLE, rnd=1, lc=0, all outputs 0 on the next cycle; no done pulse.

## Timing
- Start accepted at edge 0. LOAD is active cycle 1. done is high in cycle 12·SBOX_LAT+3 (SBOX_LAT=2 gives 27, SBOX_LAT=1 gives 15), absent stalls.
- busy is high in cycles 1 .. 12·SBOX_LAT+2.
- Exactly one of load_en / final_en / (state_en with sbox path) is active per capture cycle.
- All outputs are registered or decoded from registered state only; there are no combinational paths from start or rand_valid except as stated in Configuration.

## Configuration
- PRINCE_CTRL_RAND_STALL_EN defined:
  - In S-box phases with rand_valid=0: sbox_en, state_en, pre_add and post_add are forced to 0, and lc/rnd/phase hold.
  - rand_req stays high.
  - This is a combinational gate from rand_valid. Each stall cycle adds one cycle of latency.
- Not defined: rand_valid is ignored and latency is fixed.

## Structure
- Package prince_ctrl_pkg holds:
  - phase enum
  - LIN_NONE/LIN_M/LIN_MP/LIN_MINV encodings
  - N_FWD=5, N_INV=5, RC_FINAL=11
- Sub-module prince_layer_cnt holds the lc counter with enable, wrap at SBOX_LAT-1, and a last-cycle flag. The controller instantiates one of them.

## Test plan
- Reset, then start pulse with SBOX_LAT=2 → busy cycles 1..26, done only in cycle 27; load_en only in cycle 1; final_en only in cycle 26.
- Trace rc_idx/lin_sel per capture → sequence 0; 1..5 with M; M' (mid S); none (mid S⁻¹); 6..10 with M⁻¹; 11.
- Start re-asserted during busy, plus back-to-back start in the done cycle → first request unaffected, second run begins and done follows 27 cycles later.
- rst asserted in cycle 10 → next cycle all outputs 0, phase IDLE, no done; fresh start then completes in 27 cycles.
- With PRINCE_CTRL_RAND_STALL_EN, rand_valid=0 for 3 cycles inside FWD round 3 → sbox_en/state_en low during those cycles, done in cycle 30, capture sequence unchanged.
- SBOX_LAT=1 and SBOX_LAT=4 → done in cycles 15 and 51; state_en only on the last lc of each layer.
